// File: rtl/collision_probe.sv
// Samples eight tile-map probe points around the character box once per start,
// one probe every 2 cycles through a synchronous RAM port, then updates all four blocked flags together.
module collision_probe #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int TILE_SHIFT = 3,
  parameter int MAP_W_BITS = 5,
  parameter int MAP_H_BITS = 4,
  parameter int TILE_W     = 4,
  parameter int CHAR_W     = 8,
  parameter int CHAR_H     = 16
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            start,
  input  logic [7:0]                      char_x,
  input  logic [7:0]                      char_y,
  output logic [MAP_H_BITS+MAP_W_BITS-1:0] tile_addr,
  input  logic [TILE_W-1:0]               tile_data,
  output logic                            left_blocked,
  output logic                            right_blocked,
  output logic                            up_blocked,
  output logic                            down_blocked,
  output logic                            busy,
  output logic                            done
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, UPDATE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  k;
  logic [7:0]  lat_x, lat_y;
  logic [3:0]  hit, hit_nxt;   // {right, left, up, down}
  logic [3:0]  flags;
  logic        accept;

  function automatic logic signed [9:0] probe_px(input logic [7:0] x, input logic [2:0] p);
    logic signed [9:0] bx;
    bx = signed'({2'b00, x});
    case (p)
      3'd0, 3'd2: probe_px = bx;
      3'd1, 3'd3: probe_px = bx + 10'(CHAR_W - 1);
      3'd4, 3'd5: probe_px = bx - 10'sd1;
      default:    probe_px = bx + 10'(CHAR_W);
    endcase
  endfunction

  function automatic logic signed [9:0] probe_py(input logic [7:0] y, input logic [2:0] p);
    logic signed [9:0] by;
    by = signed'({2'b00, y});
    case (p)
      3'd0, 3'd1: probe_py = by + 10'(CHAR_H);
      3'd2, 3'd3: probe_py = by - 10'sd1;
      3'd4, 3'd6: probe_py = by;
      default:    probe_py = by + 10'(CHAR_H - 1);
    endcase
  endfunction

  // Address of the next probe: probe 0 comes straight from the inputs on the accepting edge.
  logic signed [9:0] a_px, a_py, c_px, c_py;
  logic [MAP_H_BITS+MAP_W_BITS-1:0] addr_nxt;
  logic oob_solid, oob_empty, res;

  always_comb begin
    if (accept) begin
      a_px = probe_px(char_x, 3'd0);
      a_py = probe_py(char_y, 3'd0);
    end else begin
      a_px = probe_px(lat_x, k + 3'd1);
      a_py = probe_py(lat_y, k + 3'd1);
    end
    addr_nxt = {a_py[TILE_SHIFT +: MAP_H_BITS], a_px[TILE_SHIFT +: MAP_W_BITS]};
  end

  always_comb begin
    c_px      = probe_px(lat_x, k);
    c_py      = probe_py(lat_y, k);
    oob_solid = (c_px < 10'sd0) || (c_px >= $signed(10'(SCREEN_W))) || (c_py >= $signed(10'(SCREEN_H)));
    oob_empty = (c_py < 10'sd0);
    res       = oob_solid || (!oob_empty && (tile_data != '0));
    hit_nxt   = hit;
    hit_nxt[k[2:1]] = hit[k[2:1]] | res;
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, UPDATE: state_nxt = start ? ISSUE : IDLE;
      ISSUE:        state_nxt = CAPTURE;
      CAPTURE:      state_nxt = (k == 3'd7) ? UPDATE : ISSUE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE || state == UPDATE) && start;
    busy   = (state == ISSUE) || (state == CAPTURE);
    done   = (state == UPDATE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      k         <= '0;
      lat_x     <= '0;
      lat_y     <= '0;
      hit       <= '0;
      flags     <= 4'hF;
      tile_addr <= '0;
    end else if (accept) begin
      k         <= '0;
      lat_x     <= char_x;
      lat_y     <= char_y;
      hit       <= '0;
      tile_addr <= addr_nxt;
    end else if (state == CAPTURE) begin
      hit <= hit_nxt;
      if (k == 3'd7) begin
        flags <= hit_nxt;
      end else begin
        k         <= k + 3'd1;
        tile_addr <= addr_nxt;
      end
    end
  end

  assign down_blocked  = flags[0];
  assign up_blocked    = flags[1];
  assign left_blocked  = flags[2];
  assign right_blocked = flags[3];

endmodule

// File: tb/tb_collision_probe.sv
// Scoreboarded bench for collision_probe with a behavioural tile RAM and pixel-level probe model.
module tb_collision_probe;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] char_x = '0, char_y = '0;
  logic [8:0] tile_addr;
  logic [3:0] tile_data = '0;
  logic       left_blocked, right_blocked, up_blocked, down_blocked, busy, done;

  logic [3:0] map [512];
  logic [3:0] exp_q [$];   // {right, left, up, down}
  int vectors = 0;
  int miscompares = 0;

  collision_probe dut (
    .clock(clock), .resetn(resetn), .start(start), .char_x(char_x), .char_y(char_y),
    .tile_addr(tile_addr), .tile_data(tile_data),
    .left_blocked(left_blocked), .right_blocked(right_blocked),
    .up_blocked(up_blocked), .down_blocked(down_blocked), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) tile_data <= map[tile_addr];

  function automatic logic solid_at(input int px, input int py);
    if (px < 0 || px >= 160 || py >= 120) return 1'b1;
    if (py < 0) return 1'b0;
    return map[(py / 8) * 32 + (px / 8)] != 4'd0;
  endfunction

  function automatic logic [3:0] model(input int x, input int y);
    logic dn, upf, lf, rt;
    dn  = solid_at(x, y + 16)     | solid_at(x + 7, y + 16);
    upf = solid_at(x, y - 1)      | solid_at(x + 7, y - 1);
    lf  = solid_at(x - 1, y)      | solid_at(x - 1, y + 15);
    rt  = solid_at(x + 8, y)      | solid_at(x + 8, y + 15);
    return {rt, lf, upf, dn};
  endfunction

  always @(negedge clock) begin
    if (done) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_done: done=1 with no run outstanding");
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({right_blocked, left_blocked, up_blocked, down_blocked} !== e) begin
          miscompares++;
          $display("FAIL flags x=%0d y=%0d: got {r,l,u,d}=%b expected %b",
                   dut.lat_x, dut.lat_y, {right_blocked, left_blocked, up_blocked, down_blocked}, e);
        end
      end
    end
  end

  task automatic clear_map();
    for (int i = 0; i < 512; i++) map[i] = 4'd0;
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so a follow-up call starts back-to-back.
  task automatic run_probe(input int x, input int y, input int exp_addr);
    char_x = 8'(x);
    char_y = 8'(y);
    start  = 1'b1;
    exp_q.push_back(model(x, y));
    for (int n = 1; n <= 17; n++) begin
      @(negedge clock);
      if (n == 1) start = 1'b0;
      if (n == 1 && exp_addr >= 0) begin
        vectors++;
        if (tile_addr !== 9'(exp_addr)) begin
          miscompares++;
          $display("FAIL probe0_addr: got %0d expected %0d", tile_addr, exp_addr);
        end
      end
      if (n < 17) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_window cycle T+%0d: busy=%b done=%b expected busy=1 done=0", n, busy, done);
        end
      end else begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL done_timing T+17: done=%b busy=%b expected done=1 busy=0", done, busy);
        end
      end
      if (n == 2) begin
        char_x = 8'($urandom_range(0, 255));
        char_y = 8'($urandom_range(0, 255));
      end
      if (n == 5) start = 1'b1;
      if (n == 6) start = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string name);
    vectors++;
    if ({right_blocked, left_blocked, up_blocked, down_blocked} !== 4'hF || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: flags=%b busy=%b done=%b expected flags=1111 busy=0 done=0",
               name, {right_blocked, left_blocked, up_blocked, down_blocked}, busy, done);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_state("reset_state");
    vectors++;
    if (tile_addr !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_addr: got %0d expected 0", tile_addr);
    end
    resetn = 1'b1;
    @(negedge clock);
    check_reset_state("idle_after_reset");
  endtask

  task automatic test_empty();
    clear_map();
    run_probe(72, 40, 233);
    @(negedge clock);
  endtask

  task automatic test_rows();
    clear_map();
    for (int c = 0; c < 32; c++) map[12 * 32 + c] = 4'd5;
    run_probe(72, 80, -1);
    @(negedge clock);
    clear_map();
    for (int c = 0; c < 32; c++) map[7 * 32 + c] = 4'd1;
    run_probe(72, 64, -1);
    @(negedge clock);
  endtask

  task automatic test_edges();
    clear_map();
    run_probe(0, 0, -1);
    run_probe(72, 104, -1);
    run_probe(152, 40, -1);
    @(negedge clock);
  endtask

  task automatic test_single_tile();
    clear_map();
    map[6 * 32 + 10] = 4'd9;
    run_probe(72, 40, 233);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    clear_map();
    for (int i = 0; i < 512; i++) map[i] = ($urandom_range(0, 3) == 0) ? 4'd2 : 4'd0;
    for (int r = 0; r < 6; r++)
      run_probe(int'($urandom_range(0, 170)), int'($urandom_range(0, 130)), -1);
    @(negedge clock);
  endtask

  task automatic test_abort();
    clear_map();
    char_x = 8'd72;
    char_y = 8'd40;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    check_reset_state("abort_state");
    repeat (10) @(negedge clock);
    check_reset_state("abort_no_done");
    run_probe(72, 40, 233);
    @(negedge clock);
  endtask

  initial begin
    clear_map();
    @(negedge clock);
    test_reset();
    test_empty();
    test_rows();
    test_edges();
    test_single_tile();
    test_back_to_back();
    test_abort();
    repeat (3) @(negedge clock);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
